// File: rtl/worker_pipe_pkg.sv
// worker_pipe shared types: opcodes, bundle widths, packet/result builders.
// Optional multiplier opcode is enabled by defining WORKER_MUL_EN.
package worker_pipe_pkg;

   localparam int INSN_WIDTH = 6;

   localparam logic [INSN_WIDTH-1:0] INSN_DISTRIBUTE = 6'd0;
   localparam logic [INSN_WIDTH-1:0] INSN_SWITCH     = 6'd1;
   localparam logic [INSN_WIDTH-1:0] INSN_SET_COLOR  = 6'd2;
   localparam logic [INSN_WIDTH-1:0] INSN_SYNC       = 6'd3;
   localparam logic [INSN_WIDTH-1:0] INSN_PLUS       = 6'd4;
   localparam logic [INSN_WIDTH-1:0] INSN_MINUS      = 6'd5;
   localparam logic [INSN_WIDTH-1:0] INSN_LT         = 6'd6;
   localparam logic [INSN_WIDTH-1:0] INSN_EQ         = 6'd7;
   localparam logic [INSN_WIDTH-1:0] INSN_MUL        = 6'd8;

   function automatic int packet_width(int dw, int aw, int ow, int cw);
      return 2 + INSN_WIDTH + 4 * dw + ow + aw + cw;
   endfunction

   function automatic int result_width(int dw, int aw, int ow, int cw);
      return ow + aw + cw + dw;
   endfunction

   localparam int DEF_DW = 32;
   localparam int DEF_AW = 16;
   localparam int DEF_OW = 3;
   localparam int DEF_CW = 16;
   localparam int DEF_PW = packet_width(DEF_DW, DEF_AW, DEF_OW, DEF_CW);
   localparam int DEF_RW = result_width(DEF_DW, DEF_AW, DEF_OW, DEF_CW);

   // Packet builder for the default widths; type field left at zero.
   function automatic logic [DEF_PW-1:0] make_packet(
      logic [INSN_WIDTH-1:0] insn,
      logic [DEF_DW-1:0]     d1,
      logic [DEF_DW-1:0]     d2,
      logic [DEF_DW-1:0]     d3,
      logic [DEF_DW-1:0]     d4,
      logic [DEF_OW-1:0]     opt,
      logic [DEF_AW-1:0]     addr,
      logic [DEF_CW-1:0]     color
   );
      return {2'b00, insn, d1, d2, d3, d4, opt, addr, color};
   endfunction

   // Result word builder for the default widths.
   function automatic logic [DEF_RW-1:0] make_worker_result(
      logic [DEF_OW-1:0] opt,
      logic [DEF_AW-1:0] addr,
      logic [DEF_CW-1:0] color,
      logic [DEF_DW-1:0] data
   );
      return {opt, addr, color, data};
   endfunction

endpackage

// File: rtl/worker_pipe_if.sv
// worker_pipe handshake bundle: packet input and result output channels.
// slave is the worker side, master is the surrounding pipeline side.
interface worker_pipe_if
   import worker_pipe_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int OPT_WIDTH   = 3,
   parameter int COLOR_WIDTH = 16
);
   localparam int PW =
      packet_width(DATA_WIDTH, ADDR_WIDTH, OPT_WIDTH, COLOR_WIDTH);
   localparam int RW =
      result_width(DATA_WIDTH, ADDR_WIDTH, OPT_WIDTH, COLOR_WIDTH);

   logic          RECEIVE_PC_VALID;
   logic          RECEIVE_PC_READY;
   logic [PW-1:0] RECEIVE_PC_DATA;
   logic          SEND_WR_VALID;
   logic          SEND_WR_READY;
   logic [RW-1:0] SEND_WR_DATA;

   modport master (
      output RECEIVE_PC_VALID,
      output RECEIVE_PC_DATA,
      output SEND_WR_READY,
      input  RECEIVE_PC_READY,
      input  SEND_WR_VALID,
      input  SEND_WR_DATA
   );

   modport slave (
      input  RECEIVE_PC_VALID,
      input  RECEIVE_PC_DATA,
      input  SEND_WR_READY,
      output RECEIVE_PC_READY,
      output SEND_WR_VALID,
      output SEND_WR_DATA
   );

endinterface

// File: rtl/worker_result_fifo.sv
// Result queue: up to two writes and one read per cycle, exposes occupancy.
// When empty the output holds the last popped word.
module worker_result_fifo
   import worker_pipe_pkg::*;
#(
   parameter int WIDTH = 67,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en0,
   input  logic [WIDTH-1:0] wr_data0,
   input  logic             wr_en1,
   input  logic [WIDTH-1:0] wr_data1,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [WIDTH-1:0] last_q;
   logic [CNT_W-1:0] n_push;
   logic             pop;

   // Occupancy bookkeeping for this cycle.
   always_comb begin
      n_push     = CNT_W'(wr_en0) + CNT_W'(wr_en1);
      pop        = rd_en && (count != '0);
      count_next = count + n_push - CNT_W'(pop);
   end

   assign rd_data = (count != '0) ? mem[rd_ptr] : last_q;

   // Storage, pointers and count; second write lands in the slot after the first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (wr_en0) mem[wr_ptr] <= wr_data0;
         if (wr_en1) mem[wr_ptr + PTR_W'(1)] <= wr_data1;
         wr_ptr <= wr_ptr + PTR_W'(n_push);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            last_q <= mem[rd_ptr];
         end
         count <= count_next;
      end
   end

endmodule

// File: rtl/worker_pipe.sv
// Dataflow worker: decodes one packet per cycle into 1-2 queued results.
// Define WORKER_MUL_EN to make INSN_MUL a legal single-cycle multiply.
module worker_pipe
   import worker_pipe_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int OPT_WIDTH   = 3,
   parameter int COLOR_WIDTH = 16,
   parameter int OUT_DEPTH   = 4
) (
   input  logic            CLK,
   input  logic            RST,
   worker_pipe_if.slave    bus,
   output logic            ILLEGAL_INSN
);

   localparam int DW    = DATA_WIDTH;
   localparam int CW    = COLOR_WIDTH;
   localparam int OAW   = OPT_WIDTH + ADDR_WIDTH;
   localparam int RW    = result_width(DW, ADDR_WIDTH, OPT_WIDTH, CW);
   localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

   logic [1:0]            p_type;
   logic [INSN_WIDTH-1:0] p_insn;
   logic [DW-1:0]         d1;
   logic [DW-1:0]         d2;
   logic [DW-1:0]         d3;
   logic [DW-1:0]         d4;
   logic [OPT_WIDTH-1:0]  p_opt;
   logic [ADDR_WIDTH-1:0] p_addr;
   logic [CW-1:0]         p_color;

   assign {p_type, p_insn, d1, d2, d3, d4,
           p_opt, p_addr, p_color} = bus.RECEIVE_PC_DATA;

   // Packet type and the bits above an embedded destination are ignored.
   logic unused_bits;
   assign unused_bits = ^{p_type, d3[DW-1:OAW], d4[DW-1:OAW]};

   function automatic logic [RW-1:0] pack(
      logic [OAW-1:0] dst,
      logic [CW-1:0]  col,
      logic [DW-1:0]  dat
   );
      return {dst, col, dat};
   endfunction

   logic [OAW-1:0]   pkt_dst;
   logic [1:0]       n_res;
   logic [RW-1:0]    res0;
   logic [RW-1:0]    res1;
   logic             bad;
   logic             ready_q;
   logic             illegal_q;
   logic             accept;
   logic             pop;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;

   assign pkt_dst = {p_opt, p_addr};

`ifdef WORKER_MUL_EN
   logic [DW-1:0] product;
   assign product = d1 * d2;
`endif

   // Opcode decode into result count and result words.
   always_comb begin
      n_res = 2'd0;
      res0  = '0;
      res1  = '0;
      bad   = 1'b0;
      unique case (p_insn)
         INSN_DISTRIBUTE: begin
            n_res = 2'd2;
            res0  = pack(d2[OAW-1:0], p_color, d1);
            res1  = pack(d3[OAW-1:0], p_color, d1);
         end
         INSN_SWITCH: begin
            n_res = 2'd1;
            if (d2 != '0) res0 = pack(d3[OAW-1:0], p_color, d1);
            else          res0 = pack(d4[OAW-1:0], p_color, d1);
         end
         INSN_SET_COLOR: begin
            n_res = 2'd1;
            res0  = pack(pkt_dst, d2[CW-1:0], d1);
         end
         INSN_SYNC: begin
            n_res = 2'd2;
            res0  = pack(d3[OAW-1:0], p_color, d1);
            res1  = pack(d4[OAW-1:0], p_color, d2);
         end
         INSN_PLUS: begin
            n_res = 2'd1;
            res0  = pack(pkt_dst, p_color, d1 + d2);
         end
         INSN_MINUS: begin
            n_res = 2'd1;
            res0  = pack(pkt_dst, p_color, d1 - d2);
         end
         INSN_LT: begin
            n_res = 2'd1;
            res0  = pack(pkt_dst, p_color,
                         DW'($signed(d1) < $signed(d2)));
         end
         INSN_EQ: begin
            n_res = 2'd1;
            res0  = pack(pkt_dst, p_color, DW'(d1 == d2));
         end
`ifdef WORKER_MUL_EN
         INSN_MUL: begin
            n_res = 2'd1;
            res0  = pack(pkt_dst, p_color, product);
         end
`endif
         default: bad = 1'b1;
      endcase
   end

   assign accept = bus.RECEIVE_PC_VALID && ready_q;
   assign pop    = bus.SEND_WR_VALID && bus.SEND_WR_READY;

   worker_result_fifo #(
      .WIDTH (RW),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk        (CLK),
      .rst_n      (RST),
      .wr_en0     (accept && (n_res != 2'd0)),
      .wr_data0   (res0),
      .wr_en1     (accept && (n_res == 2'd2)),
      .wr_data1   (res1),
      .rd_en      (pop),
      .rd_data    (bus.SEND_WR_DATA),
      .count      (count),
      .count_next (count_next)
   );

   assign bus.SEND_WR_VALID    = (count != '0);
   assign bus.RECEIVE_PC_READY = ready_q;
   assign ILLEGAL_INSN         = illegal_q;

   // Accept only while two slots will be free; flag consumed bad opcodes.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ready_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         ready_q   <= (count_next <= CNT_W'(OUT_DEPTH - 2));
         illegal_q <= accept && bad;
      end
   end

endmodule

// File: tb/tb_worker_pipe.sv
// Bench for worker_pipe: opcode vector table plus backpressure/reset sequences.
// Honours WORKER_MUL_EN for the INSN_MUL vector.
module tb_worker_pipe;
   import worker_pipe_pkg::*;

   localparam int PW = DEF_PW;
   localparam int RW = DEF_RW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic illegal;

   worker_pipe_if bus ();

   worker_pipe dut (
      .CLK          (clk),
      .RST          (rst_n),
      .bus          (bus),
      .ILLEGAL_INSN (illegal)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [RW-1:0] exp_q [$];

   task automatic check_bit(input string name, input logic act,
                            input logic want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", name, act, want);
      end
   endtask

   task automatic check_res(input string name, input logic [RW-1:0] act,
                            input logic [RW-1:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Scoreboard: compare each popped result, and hold stability while stalled.
   logic          stall_prev = 1'b0;
   logic [RW-1:0] prev_data  = '0;
   always @(negedge clk) begin
      if (rst_n && bus.SEND_WR_VALID) begin
         if (stall_prev) check_res("hold", bus.SEND_WR_DATA, prev_data);
         if (bus.SEND_WR_READY) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra: got %h want none", bus.SEND_WR_DATA);
            end else begin
               check_res("result", bus.SEND_WR_DATA, exp_q.pop_front());
            end
         end
      end
      stall_prev <= rst_n && bus.SEND_WR_VALID && !bus.SEND_WR_READY;
      prev_data  <= bus.SEND_WR_DATA;
   end

   task automatic wait_accept(input string name);
      bit ok = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.RECEIVE_PC_READY) begin
            @(posedge clk);
            #1;
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got no accept want accept", name);
      end
      bus.RECEIVE_PC_VALID = 1'b0;
   endtask

   task automatic drive(input logic [PW-1:0] p, input int n,
                        input logic [RW-1:0] e0, input logic [RW-1:0] e1);
      if (n > 0) exp_q.push_back(e0);
      if (n > 1) exp_q.push_back(e1);
      bus.RECEIVE_PC_VALID = 1'b1;
      bus.RECEIVE_PC_DATA  = p;
      wait_accept("accept");
   endtask

   typedef struct {
      logic [5:0]    insn;
      logic [31:0]   d1, d2, d3, d4;
      logic [2:0]    opt;
      logic [15:0]   addr, color;
      int            n;
      logic [RW-1:0] e0, e1;
      logic          bad;
   } vec_t;

   function automatic vec_t mkv(
      logic [5:0] insn, logic [31:0] d1, logic [31:0] d2,
      logic [31:0] d3, logic [31:0] d4, logic [2:0] opt,
      logic [15:0] addr, logic [15:0] color, int n,
      logic [RW-1:0] e0, logic [RW-1:0] e1, logic bad);
      vec_t v;
      v.insn = insn; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.d4 = d4;
      v.opt = opt; v.addr = addr; v.color = color;
      v.n = n; v.e0 = e0; v.e1 = e1; v.bad = bad;
      return v;
   endfunction

   function automatic logic [RW-1:0] r(logic [2:0] o, logic [15:0] a,
                                      logic [15:0] c, logic [31:0] d);
      return make_worker_result(o, a, c, d);
   endfunction

   vec_t tbl [14];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [PW-1:0] pc;
      bus.RECEIVE_PC_VALID = 1'b0;
      bus.RECEIVE_PC_DATA  = '0;
      bus.SEND_WR_READY    = 1'b1;

      tbl[0]  = mkv(INSN_DISTRIBUTE, 32'hdeadbeef, 32'hfff2dead,
                    32'h0005beef, 32'h0, 3'd0, 16'h0, 16'h0f0f, 2,
                    r(3'b010, 16'hdead, 16'h0f0f, 32'hdeadbeef),
                    r(3'b101, 16'hbeef, 16'h0f0f, 32'hdeadbeef), 1'b0);
      tbl[1]  = mkv(INSN_SWITCH, 32'h11111111, 32'h0, 32'h00010001,
                    32'h00031234, 3'd0, 16'h0, 16'h00aa, 1,
                    r(3'd3, 16'h1234, 16'h00aa, 32'h11111111), '0, 1'b0);
      tbl[2]  = mkv(INSN_SWITCH, 32'h22222222, 32'h7, 32'h00010001,
                    32'h00031234, 3'd0, 16'h0, 16'h00aa, 1,
                    r(3'd1, 16'h0001, 16'h00aa, 32'h22222222), '0, 1'b0);
      tbl[3]  = mkv(INSN_SET_COLOR, 32'hcafef00d, 32'h0000badc, 32'h0,
                    32'h0, 3'd6, 16'h4321, 16'habcd, 1,
                    r(3'd6, 16'h4321, 16'hbadc, 32'hcafef00d), '0, 1'b0);
      tbl[4]  = mkv(INSN_SYNC, 32'haaaa0001, 32'hbbbb0002, 32'h00070010,
                    32'h00000020, 3'd0, 16'h0, 16'h1234, 2,
                    r(3'd7, 16'h0010, 16'h1234, 32'haaaa0001),
                    r(3'd0, 16'h0020, 16'h1234, 32'hbbbb0002), 1'b0);
      tbl[5]  = mkv(INSN_PLUS, 32'hffffffff, 32'h1, 32'h0, 32'h0,
                    3'd2, 16'h0100, 16'h5555, 1,
                    r(3'd2, 16'h0100, 16'h5555, 32'h0), '0, 1'b0);
      tbl[6]  = mkv(INSN_PLUS, 32'h3, 32'h4, 32'h0, 32'h0,
                    3'd2, 16'h0100, 16'h5555, 1,
                    r(3'd2, 16'h0100, 16'h5555, 32'h7), '0, 1'b0);
      tbl[7]  = mkv(INSN_MINUS, 32'h0, 32'h1, 32'h0, 32'h0,
                    3'd2, 16'h0100, 16'h5555, 1,
                    r(3'd2, 16'h0100, 16'h5555, 32'hffffffff), '0, 1'b0);
      tbl[8]  = mkv(INSN_LT, 32'hffffffff, 32'h1, 32'h0, 32'h0,
                    3'd2, 16'h0100, 16'h5555, 1,
                    r(3'd2, 16'h0100, 16'h5555, 32'h1), '0, 1'b0);
      tbl[9]  = mkv(INSN_LT, 32'h1, 32'hffffffff, 32'h0, 32'h0,
                    3'd2, 16'h0100, 16'h5555, 1,
                    r(3'd2, 16'h0100, 16'h5555, 32'h0), '0, 1'b0);
      tbl[10] = mkv(INSN_EQ, 32'h5, 32'h5, 32'h0, 32'h0,
                    3'd2, 16'h0100, 16'h5555, 1,
                    r(3'd2, 16'h0100, 16'h5555, 32'h1), '0, 1'b0);
      tbl[11] = mkv(INSN_EQ, 32'h5, 32'h6, 32'h0, 32'h0,
                    3'd2, 16'h0100, 16'h5555, 1,
                    r(3'd2, 16'h0100, 16'h5555, 32'h0), '0, 1'b0);
      tbl[12] = mkv(6'h3f, 32'h1, 32'h2, 32'h3, 32'h4,
                    3'd1, 16'h0001, 16'h0001, 0, '0, '0, 1'b1);
`ifdef WORKER_MUL_EN
      tbl[13] = mkv(INSN_MUL, 32'h3, 32'h7, 32'h0, 32'h0,
                    3'd4, 16'h0200, 16'h7777, 1,
                    r(3'd4, 16'h0200, 16'h7777, 32'd21), '0, 1'b0);
`else
      tbl[13] = mkv(INSN_MUL, 32'h3, 32'h7, 32'h0, 32'h0,
                    3'd4, 16'h0200, 16'h7777, 0, '0, '0, 1'b1);
`endif

      // Reset state and READY release timing.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_bit("rst_ready", bus.RECEIVE_PC_READY, 1'b0);
      check_bit("rst_valid", bus.SEND_WR_VALID, 1'b0);
      check_res("rst_data", bus.SEND_WR_DATA, '0);
      check_bit("rst_illegal", illegal, 1'b0);
      rst_n = 1'b1;
      #1;
      check_bit("ready_pre_edge", bus.RECEIVE_PC_READY, 1'b0);
      @(posedge clk);
      #1;
      check_bit("ready_post_edge", bus.RECEIVE_PC_READY, 1'b1);

      // Opcode table.
      for (int i = 0; i < 14; i++) begin
         pc = make_packet(tbl[i].insn, tbl[i].d1, tbl[i].d2, tbl[i].d3,
                          tbl[i].d4, tbl[i].opt, tbl[i].addr,
                          tbl[i].color);
         drive(pc, tbl[i].n, tbl[i].e0, tbl[i].e1);
         check_bit("illegal", illegal, tbl[i].bad);
         @(posedge clk);
         #1;
         check_bit("illegal_pulse", illegal, 1'b0);
      end

      // Backpressure: two SYNC packets fill the FIFO.
      bus.SEND_WR_READY = 1'b0;
      drive(make_packet(INSN_SYNC, 32'ha1, 32'ha2, 32'h00010011,
                        32'h00020022, 3'd0, 16'h0, 16'hc001), 2,
            r(3'd1, 16'h0011, 16'hc001, 32'ha1),
            r(3'd2, 16'h0022, 16'hc001, 32'ha2));
      check_bit("ready_cnt2", bus.RECEIVE_PC_READY, 1'b1);
      drive(make_packet(INSN_SYNC, 32'hb1, 32'hb2, 32'h00030033,
                        32'h00040044, 3'd0, 16'h0, 16'hc002), 2,
            r(3'd3, 16'h0033, 16'hc002, 32'hb1),
            r(3'd4, 16'h0044, 16'hc002, 32'hb2));
      check_bit("ready_full", bus.RECEIVE_PC_READY, 1'b0);
      exp_q.push_back(r(3'd5, 16'h0055, 16'hc003, 32'hc1));
      exp_q.push_back(r(3'd6, 16'h0066, 16'hc003, 32'hc2));
      bus.RECEIVE_PC_VALID = 1'b1;
      bus.RECEIVE_PC_DATA  = make_packet(INSN_SYNC, 32'hc1, 32'hc2,
                                         32'h00050055, 32'h00060066,
                                         3'd0, 16'h0, 16'hc003);
      repeat (3) begin
         @(negedge clk);
         check_bit("stall_ready", bus.RECEIVE_PC_READY, 1'b0);
         check_bit("stall_valid", bus.SEND_WR_VALID, 1'b1);
      end
      @(posedge clk);
      #1;
      bus.SEND_WR_READY = 1'b1;
      wait_accept("accept_c");
      check_bit("ready_cnt3", bus.RECEIVE_PC_READY, 1'b0);
      drive(make_packet(INSN_PLUS, 32'h10, 32'h20, 32'h0, 32'h0,
                        3'd7, 16'h0777, 16'hc004), 1,
            r(3'd7, 16'h0777, 16'hc004, 32'h30), '0);
      drive(make_packet(INSN_DISTRIBUTE, 32'he1, 32'h00010101,
                        32'h00020202, 32'h0, 3'd0, 16'h0, 16'hc005), 2,
            r(3'd1, 16'h0101, 16'hc005, 32'he1),
            r(3'd2, 16'h0202, 16'hc005, 32'he1));

      // Drain and confirm nothing is left over.
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      check_bit("drained", exp_q.size() == 0, 1'b1);
      check_bit("empty_valid", bus.SEND_WR_VALID, 1'b0);

      // Reset with a queued result discards it.
      bus.SEND_WR_READY = 1'b0;
      drive(make_packet(INSN_PLUS, 32'h1, 32'h1, 32'h0, 32'h0,
                        3'd1, 16'h0009, 16'h0009), 1,
            r(3'd1, 16'h0009, 16'h0009, 32'h2), '0);
      @(negedge clk);
      check_bit("queued_valid", bus.SEND_WR_VALID, 1'b1);
      rst_n = 1'b0;
      #1;
      check_bit("midrst_valid", bus.SEND_WR_VALID, 1'b0);
      check_res("midrst_data", bus.SEND_WR_DATA, '0);
      check_bit("midrst_ready", bus.RECEIVE_PC_READY, 1'b0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.SEND_WR_READY = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_bit("no_replay", bus.SEND_WR_VALID, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
